// File: rtl/if_stage_buf.sv
// rtl/if_stage_buf.sv - fetch/decode stage buffer with valid/ready handshake and 2-entry skid
module if_stage_buf #(
   parameter int                    WORD_WIDTH = 32,
   parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    CNT_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  freeze,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WORD_WIDTH-1:0] pc_in,
   input  logic [WORD_WIDTH-1:0] instruction_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORD_WIDTH-1:0] pc,
   output logic [WORD_WIDTH-1:0] instruction,
   output logic [1:0]            occupancy,
   output logic [CNT_W-1:0]      squash_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t                state;
   logic                  out_valid_q;
   logic [WORD_WIDTH-1:0] head_pc;
   logic [WORD_WIDTH-1:0] head_instr;
   logic [WORD_WIDTH-1:0] skid_pc;
   logic [WORD_WIDTH-1:0] skid_instr;
   logic [CNT_W-1:0]      squash_q;
   logic [CNT_W:0]        squash_sum;
   logic [CNT_W-1:0]      squash_next;
   logic                  in_fire;
   logic                  out_fire;

   // in_ready depends only on freeze and registered state, never on out_ready
   assign in_ready = ~freeze & (state != FULL);
   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid_q & out_ready & ~freeze;

   // one extra bit catches the carry so the counter saturates instead of wrapping
   assign squash_sum  = (CNT_W+1)'(squash_q) + (CNT_W+1)'(state);
   assign squash_next = squash_sum[CNT_W] ? {CNT_W{1'b1}} : squash_sum[CNT_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= EMPTY;
         out_valid_q <= 1'b0;
         head_pc     <= RESET_PC;
         head_instr  <= '0;
         skid_pc     <= '0;
         skid_instr  <= '0;
         squash_q    <= '0;
      end else if (!freeze) begin
         if (flush) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            head_pc     <= RESET_PC;
            head_instr  <= '0;
            skid_pc     <= '0;
            skid_instr  <= '0;
            squash_q    <= squash_next;
         end else begin
            case (state)
               EMPTY: begin
                  if (in_fire) begin
                     head_pc     <= pc_in;
                     head_instr  <= instruction_in;
                     state       <= ONE;
                     out_valid_q <= 1'b1;
                  end
               end
               ONE: begin
                  if (in_fire && out_fire) begin
                     head_pc    <= pc_in;
                     head_instr <= instruction_in;
                  end else if (in_fire) begin
                     skid_pc    <= pc_in;
                     skid_instr <= instruction_in;
                     state      <= FULL;
                  end else if (out_fire) begin
                     state       <= EMPTY;
                     out_valid_q <= 1'b0;
                  end
               end
               FULL: begin
                  if (out_fire) begin
                     head_pc    <= skid_pc;
                     head_instr <= skid_instr;
                     state      <= ONE;
                  end
               end
               default: begin
                  state       <= EMPTY;
                  out_valid_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign pc          = head_pc;
   assign instruction = head_instr;
   assign occupancy   = state;
   assign squash_cnt  = squash_q;

endmodule

// File: tb/tb_if_stage_buf.sv
// tb/tb_if_stage_buf.sv - randomized bench for if_stage_buf against a queue-based reference model
module tb_if_stage_buf;

   localparam int          W        = 32;
   localparam logic [31:0] RST_PC   = 32'h0000_0F00;
   localparam int          MAX8     = 255;
   localparam int          MAX2     = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        freeze = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] pc_in = '0;
   logic [31:0] instruction_in = '0;

   logic        in_ready, out_valid;
   logic [31:0] pc, instruction;
   logic [1:0]  occupancy;
   logic [7:0]  squash_cnt;

   logic        s_in_ready, s_out_valid;
   logic [31:0] s_pc, s_instruction;
   logic [1:0]  s_occupancy;
   logic [1:0]  s_squash_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] q_pc[$];
   logic [31:0] q_in[$];
   logic [31:0] shown_pc;
   logic [31:0] shown_in;
   int          sq8;
   int          sq2;

   always #5 clk = ~clk;

   if_stage_buf #(.WORD_WIDTH(W), .RESET_PC(RST_PC), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .pc_in(pc_in), .instruction_in(instruction_in),
      .out_valid(out_valid), .out_ready(out_ready), .pc(pc), .instruction(instruction),
      .occupancy(occupancy), .squash_cnt(squash_cnt)
   );

   if_stage_buf #(.WORD_WIDTH(W), .RESET_PC(RST_PC), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
      .in_valid(in_valid), .in_ready(s_in_ready), .pc_in(pc_in), .instruction_in(instruction_in),
      .out_valid(s_out_valid), .out_ready(out_ready), .pc(s_pc), .instruction(s_instruction),
      .occupancy(s_occupancy), .squash_cnt(s_squash_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      q_pc.delete();
      q_in.delete();
      shown_pc = RST_PC;
      shown_in = '0;
      sq8 = 0;
      sq2 = 0;
   endtask

   task automatic check_outputs();
      check("out_valid", 32'(out_valid), 32'(q_pc.size() != 0));
      check("pc", pc, shown_pc);
      check("instruction", instruction, shown_in);
      check("occupancy", 32'(occupancy), 32'(q_pc.size()));
      check("squash_cnt", 32'(squash_cnt), 32'(sq8));
      check("squash_cnt_sat", 32'(s_squash_cnt), 32'(sq2));
      check("sat_pc", s_pc, shown_pc);
   endtask

   task automatic cycle(input logic iv, input logic [31:0] p, input logic [31:0] ins,
                        input logic ordy, input logic frz, input logic fl);
      int  n;
      bit  of, inf;
      in_valid = iv; pc_in = p; instruction_in = ins;
      out_ready = ordy; freeze = frz; flush = fl;
      #1;
      check("in_ready", 32'(in_ready), 32'(!frz && q_pc.size() < 2));
      @(posedge clk);
      n = q_pc.size();
      if (!frz) begin
         if (fl) begin
            sq8 = (sq8 + n > MAX8) ? MAX8 : sq8 + n;
            sq2 = (sq2 + n > MAX2) ? MAX2 : sq2 + n;
            q_pc.delete();
            q_in.delete();
            shown_pc = RST_PC;
            shown_in = '0;
         end else begin
            of  = (n > 0) && ordy;
            inf = iv && (n < 2);
            if (of) begin
               void'(q_pc.pop_front());
               void'(q_in.pop_front());
            end
            if (inf) begin
               q_pc.push_back(p);
               q_in.push_back(ins);
            end
            if (q_pc.size() > 0) begin
               shown_pc = q_pc[0];
               shown_in = q_in[0];
            end
         end
      end
      #1;
      check_outputs();
   endtask

   function automatic logic [31:0] ins_of(input logic [31:0] p);
      return p ^ 32'hDEAD_0000;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      check("in_ready_rst", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // streaming at full rate
      cycle(1, 32'h100, ins_of(32'h100), 1, 0, 0);
      cycle(1, 32'h104, ins_of(32'h104), 1, 0, 0);
      cycle(1, 32'h108, ins_of(32'h108), 1, 0, 0);
      cycle(0, 32'h0,   32'h0,           1, 0, 0);

      // skid fill then drain
      cycle(1, 32'h200, ins_of(32'h200), 0, 0, 0);
      cycle(1, 32'h204, ins_of(32'h204), 0, 0, 0);
      cycle(1, 32'h208, ins_of(32'h208), 0, 0, 0);
      cycle(1, 32'h208, ins_of(32'h208), 1, 0, 0);
      cycle(1, 32'h208, ins_of(32'h208), 1, 0, 0);
      cycle(0, 32'h0,   32'h0,           1, 0, 0);

      // freeze overrides flush and transfers
      cycle(1, 32'h300, ins_of(32'h300), 0, 0, 0);
      cycle(1, 32'h304, ins_of(32'h304), 0, 0, 0);
      repeat (3) cycle(1, 32'h308, ins_of(32'h308), 1, 1, 1);
      repeat (3) cycle(0, 32'h0, 32'h0, 1, 0, 0);

      // flush at occupancy 2, then at 0, then 2 (saturates CNT_W=2), then 1
      cycle(1, 32'h400, ins_of(32'h400), 0, 0, 0);
      cycle(1, 32'h404, ins_of(32'h404), 0, 0, 0);
      cycle(1, 32'h408, ins_of(32'h408), 1, 0, 1);
      cycle(0, 32'h0,   32'h0,           1, 0, 1);
      cycle(1, 32'h500, ins_of(32'h500), 0, 0, 0);
      cycle(1, 32'h504, ins_of(32'h504), 0, 0, 0);
      cycle(0, 32'h0,   32'h0,           1, 0, 1);
      cycle(1, 32'h600, ins_of(32'h600), 0, 0, 0);
      cycle(0, 32'h0,   32'h0,           1, 0, 1);

      // async reset between clock edges with two entries held
      cycle(1, 32'h700, ins_of(32'h700), 0, 0, 0);
      cycle(1, 32'h704, ins_of(32'h704), 0, 0, 0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1, 32'h800, ins_of(32'h800), 0, 0, 0);
      cycle(0, 32'h0,   32'h0,           1, 0, 0);

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         logic [31:0] rp;
         logic [31:0] ri;
         rp = $urandom;
         ri = $urandom;
         cycle(($urandom_range(0, 9) < 7), rp, ri, ($urandom_range(0, 9) < 6),
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
